// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   kp_state_t  : scanner FSM state encoding
//   KEY_CODE    : 4-bit code of each key, indexed [row][col]
//   lowest_low  : index of the lowest-numbered active-low row in a row vector
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HOLD        = 2'd2,
        DEB_RELEASE = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_CODE [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Only meaningful when at least one bit of rows is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key output bundle from the keypad scanner to the data-entry stage.
//   entrada  : code of the last accepted key
//   push     : one-cycle strobe, entrada valid in the same cycle
//   key_held : accepted key still held (release not yet debounced)
// master = scanner side (drives), slave = data-entry side (receives).
interface keypad_scanner_if;
    logic [3:0] entrada;
    logic       push;
    logic       key_held;

    modport master (output entrada, output push, output key_held);
    modport slave  (input  entrada, input  push, input  key_held);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-stage synchronizer for the asynchronous keypad rows.
//   clk : sampling clock
//   rst : asynchronous active-low reset; both stages reset to all-ones
//         (idle level of the pulled-up rows)
//   d   : asynchronous input
//   q   : synchronized output
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and key encoding.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   row_in  : keypad rows, active-low, asynchronous
//   col_out : column drive, active-low, one bit low at a time
//   kp      : entrada / push / key_held towards the data-entry stage
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SCAN        | rotate columns, sample rows on last cycle of each column
// DEB_PRESS   | column frozen, count stable-low cycles of the latched row
// HOLD        | key accepted and held, waiting for the latched row to rise
// DEB_RELEASE | count stable-high cycles before resuming the scan
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 27000,
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    keypad_scanner_if.master kp
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  PRESS_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    // The HOLD cycle that first sees the row high is itself the first of the
    // DEBOUNCE_CYCLES high samples, so DEB_RELEASE needs one fewer.
    localparam logic [DEB_W-1:0]  REL_LAST   = DEB_W'(DEBOUNCE_CYCLES - 2);

    logic [3:0]        row_s;
    kp_state_t         state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [3:0]        ent_q, ent_d;
    logic              push;
    logic              row_hi;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (row_s)
    );

    assign row_hi = row_s[row_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            scan_q  <= '0;
            deb_q   <= '0;
            ent_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            deb_q   <= deb_d;
            ent_q   <= ent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        scan_d  = scan_q;
        deb_d   = deb_q;
        ent_d   = ent_q;
        push    = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (scan_q == SCAN_LAST) begin
                    scan_d = '0;
                    if (row_s != 4'hF) begin
                        row_d   = lowest_low(row_s);
                        deb_d   = '0;
                        state_d = DEB_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else if (scan_q != '1) begin
                    scan_d = scan_q + 1'b1;
                end
            end

            DEB_PRESS: begin
                if (row_hi) begin
                    deb_d   = '0;
                    scan_d  = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (deb_q == PRESS_LAST) begin
                    push    = 1'b1;
                    ent_d   = KEY_CODE[row_q][col_q];
                    deb_d   = '0;
                    state_d = HOLD;
                end else if (deb_q != '1) begin
                    deb_d = deb_q + 1'b1;
                end
            end

            HOLD: begin
                if (row_hi) begin
                    deb_d   = '0;
                    state_d = DEB_RELEASE;
                end
            end

            DEB_RELEASE: begin
                if (!row_hi) begin
                    deb_d   = '0;
                    state_d = HOLD;
                end else if (deb_q == REL_LAST) begin
                    deb_d   = '0;
                    scan_d  = '0;
                    col_d   = col_q + 2'd1;
                    state_d = SCAN;
                end else if (deb_q != '1) begin
                    deb_d = deb_q + 1'b1;
                end
            end

            default: state_d = SCAN;
        endcase
    end

    assign col_out     = ~(4'b0001 << col_q);
    // The new code is presented during the push cycle itself; ent_q picks it
    // up at the end of that cycle and holds it afterwards.
    assign kp.entrada  = push ? ent_d : ent_q;
    assign kp.push     = push;
    assign kp.key_held = (state_q == HOLD) || (state_q == DEB_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int S = 4;
    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;

    bit         pressed [4][4];
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;
    logic       prev_push = 1'b0;
    logic [3:0] last_ent  = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .SCAN_CYCLES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .kp      (kp_if)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that
    // column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && col_out[c] == 1'b0)
                    row_in[r] = 1'b0;
    end

    // Key legend arithmetic: digits 1-9 fill rows 0-2 of columns 0-2,
    // letters A-D run down column 3, bottom row is *, 0, #.
    function automatic logic [3:0] exp_code(input int r, input int c);
        if (c == 3) return 4'(10 + r);
        if (r < 3)  return 4'(r * 3 + c + 1);
        if (c == 0) return 4'hE;
        if (c == 1) return 4'h0;
        return 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst) begin
            check("col_onehot", 32'($onehot(~col_out)), 32'd1);
            if (kp_if.push) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_push actual entrada %0h required no push", kp_if.entrada);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("entrada", kp_if.entrada, mon_exp);
                end
                check("held_low_at_push", kp_if.key_held, 1'b0);
            end else if (kp_if.entrada !== last_ent) begin
                n_checks++;
                n_errors++;
                $display("FAIL entrada_changed_without_push actual %0h required %0h", kp_if.entrada, last_ent);
            end
            if (prev_push) check("held_after_push", kp_if.key_held, 1'b1);
        end
        prev_push = rst && kp_if.push;
        last_ent  = kp_if.entrada;
    end

    task automatic wait_held(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (kp_if.key_held !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (kp_if.key_held !== lvl) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout actual key_held %0b required %0b", tag, kp_if.key_held, lvl);
        end
    endtask

    // Called right after the key(s) are released at a negedge: the row reaches
    // row_s two edges later, and key_held must fall D cycles after that.
    task automatic measure_release(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (kp_if.key_held && n < 100);
        check(tag, n, D + 2);
    endtask

    task automatic press_release(input int r, input int c, input int hold);
        @(negedge clk);
        exp_q.push_back(exp_code(r, c));
        pressed[r][c] = 1'b1;
        wait_held(1'b1, 300, "press_accept");
        repeat (hold) @(negedge clk);
        pressed[r][c] = 1'b0;
        measure_release("release_latency");
        repeat ($urandom_range(0, 10)) @(negedge clk);
    endtask

    task automatic check_scan_start(input string tag);
        for (int i = 0; i < S - 1; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_col0"}, col_out, 4'b1110);
        end
        @(posedge clk);
        #1;
        check({tag, "_col1"}, col_out, 4'b1101);
    endtask

    initial begin
        bit held_ok;
        int r, c;

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                pressed[i][j] = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        #1;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_push", kp_if.push, 1'b0);
        check("rst_entrada", kp_if.entrada, 4'h0);
        check("rst_key_held", kp_if.key_held, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_release_col", col_out, 4'b1110);
        check_scan_start("scan_after_por");

        // Reset asserted while a key ("1") is held.
        @(negedge clk);
        exp_q.push_back(exp_code(0, 0));
        pressed[0][0] = 1'b1;
        wait_held(1'b1, 300, "press_1");
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_col_out", col_out, 4'b1110);
        check("midrst_push", kp_if.push, 1'b0);
        check("midrst_entrada", kp_if.entrada, 4'h0);
        check("midrst_key_held", kp_if.key_held, 1'b0);
        pressed[0][0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        check_scan_start("scan_after_midrst");

        // Clean press of "5".
        press_release(1, 1, 40);

        // Bouncing "9": never low long enough to be accepted.
        @(negedge clk);
        repeat (15) begin
            pressed[2][2] = 1'b1;
            repeat (3) @(negedge clk);
            pressed[2][2] = 1'b0;
            @(negedge clk);
        end
        check("bounce_no_hold", kp_if.key_held, 1'b0);
        press_release(2, 2, 10);

        // Release bounce on "#".
        @(negedge clk);
        exp_q.push_back(exp_code(3, 2));
        pressed[3][2] = 1'b1;
        wait_held(1'b1, 300, "press_hash");
        repeat (10) @(negedge clk);
        held_ok = 1'b1;
        pressed[3][2] = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 4) pressed[3][2] = 1'b1;
            if (!kp_if.key_held) held_ok = 1'b0;
        end
        check("held_through_release_bounce", held_ok, 1'b1);
        pressed[3][2] = 1'b0;
        measure_release("release_after_bounce");

        // "4" and "*" in the same column; "D" pressed during HOLD.
        @(negedge clk);
        exp_q.push_back(exp_code(1, 0));
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        wait_held(1'b1, 300, "press_4_star");
        repeat (5) @(negedge clk);
        pressed[3][3] = 1'b1;
        repeat (20) @(negedge clk);
        pressed[1][0] = 1'b0;
        pressed[3][0] = 1'b0;
        measure_release("release_4_star");
        exp_q.push_back(exp_code(3, 3));
        @(negedge clk);
        wait_held(1'b1, 300, "press_d_after");
        repeat (10) @(negedge clk);
        pressed[3][3] = 1'b0;
        measure_release("release_d");

        // Full map sweep, row-major.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                press_release(i, j, int'($urandom_range(2, 20)));

        // Random keys in random order.
        repeat (10) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            press_release(r, c, int'($urandom_range(1, 30)));
        end

        repeat (50) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
